// File: rtl/video_sync_sequencer_pkg.sv
// Shared video timing defaults, the 9-bit count type and the half-open window compare.
package video_timing_pkg;

   typedef logic [8:0] count_t;

   localparam int H_TOTAL_DEF  = 455;
   localparam int H_BLANK_DEF  = 80;
   localparam int H_SYNC_S_DEF = 32;
   localparam int H_SYNC_E_DEF = 64;
   localparam int V_TOTAL_DEF  = 262;
   localparam int V_BLANK_DEF  = 16;
   localparam int V_SYNC_S_DEF = 4;
   localparam int V_SYNC_E_DEF = 8;

   localparam count_t NET_HCNT = 9'd256;

   // Bounds are 10 bits wide so that an end value of 512 is still representable.
   function automatic logic in_window(count_t cnt, logic [9:0] s, logic [9:0] e);
      return ({1'b0, cnt} >= s) && ({1'b0, cnt} < e);
   endfunction

endpackage

// File: rtl/video_sync_sequencer_mod_counter.sv
// Synchronous modulo-N counter with clock enable and a combinational wrap strobe.
module mod_counter #(
   parameter int N = 455,
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cnt_next,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   if (N < 1 || N > (1 << W)) begin : g_bad_n
      $error("mod_counter: N=%0d does not fit in W=%0d bits", N, W);
   end

   assign wrap = ce && (cnt == LAST);

   always_comb begin
      cnt_next = cnt;
      if (ce) begin
         cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/video_sync_sequencer.sv
// Pong horizontal/vertical counter chain with registered sync, blank and start decode.
// Optional centre-net decode is built only when PONG_NET_EN is defined.
module video_sync_sequencer
   import video_timing_pkg::*;
#(
   parameter int H_TOTAL  = H_TOTAL_DEF,
   parameter int H_BLANK  = H_BLANK_DEF,
   parameter int H_SYNC_S = H_SYNC_S_DEF,
   parameter int H_SYNC_E = H_SYNC_E_DEF,
   parameter int V_TOTAL  = V_TOTAL_DEF,
   parameter int V_BLANK  = V_BLANK_DEF,
   parameter int V_SYNC_S = V_SYNC_S_DEF,
   parameter int V_SYNC_E = V_SYNC_E_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce_pix,
   output logic [8:0] hcnt,
   output logic [8:0] vcnt,
   output logic       hblank,
   output logic       vblank,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       line_start,
   output logic       frame_start,
   output logic       net
);

   if (H_TOTAL > 512 || V_TOTAL > 512 || H_BLANK > H_TOTAL || V_BLANK > V_TOTAL ||
       !(H_SYNC_S < H_SYNC_E && H_SYNC_E <= H_TOTAL) ||
       !(V_SYNC_S < V_SYNC_E && V_SYNC_E <= V_TOTAL)) begin : g_bad_params
      $error("video_sync_sequencer: timing parameters out of range");
   end

   count_t h_next;
   count_t v_next;
   logic   h_wrap;
   logic   v_wrap;

   mod_counter #(.N(H_TOTAL), .W(9)) u_hcnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (ce_pix),
      .cnt      (hcnt),
      .cnt_next (h_next),
      .wrap     (h_wrap)
   );

   // The vertical counter only steps on the last pixel of a line.
   mod_counter #(.N(V_TOTAL), .W(9)) u_vcnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (h_wrap),
      .cnt      (vcnt),
      .cnt_next (v_next),
      .wrap     (v_wrap)
   );

   // Decode from the next counts so every output lines up with hcnt/vcnt.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hblank      <= 1'b1;
         vblank      <= 1'b1;
         hsync_n     <= 1'b1;
         vsync_n     <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (ce_pix) begin
         hblank      <= in_window(h_next, 10'd0, 10'(H_BLANK));
         vblank      <= in_window(v_next, 10'd0, 10'(V_BLANK));
         hsync_n     <= !in_window(h_next, 10'(H_SYNC_S), 10'(H_SYNC_E));
         vsync_n     <= !in_window(v_next, 10'(V_SYNC_S), 10'(V_SYNC_E));
         line_start  <= h_wrap;
         frame_start <= h_wrap && v_wrap;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

`ifdef PONG_NET_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         net <= 1'b0;
      end else if (ce_pix) begin
         net <= (h_next == NET_HCNT) && !in_window(v_next, 10'd0, 10'(V_BLANK)) && v_next[2];
      end
   end
`else
   assign net = 1'b0;
`endif

endmodule
